// File: rtl/tbb_loader.sv
// rtl/tbb_loader.sv - loads cache-line batches from host memory into task batch buffers
module tbb_loader #(
    parameter int NUM_TBB         = 4,
    parameter int LINE_IDX_WIDTH  = 6,
    parameter int LINE_DATA_WIDTH = 512,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        start,
    input  logic [ADDR_WIDTH-1:0]                       base_addr,
    input  logic [ADDR_WIDTH-LINE_IDX_WIDTH-1:0]        num_batches,
    output logic                                        done,
    input  logic [NUM_TBB-1:0]                          tbb_req_valid,
    input  logic [NUM_TBB*LINE_IDX_WIDTH-1:0]           tbb_req_line_idx,
    output logic [NUM_TBB-1:0]                          tbb_req_ack,
    output logic [NUM_TBB-1:0]                          tbb_wr_en,
    output logic [LINE_IDX_WIDTH-1:0]                   tbb_wr_addr,
    output logic [LINE_DATA_WIDTH-1:0]                  tbb_wr_din,
    output logic                                        rd_req_valid,
    output logic [ADDR_WIDTH-1:0]                       rd_req_addr,
    output logic [$clog2(NUM_TBB)+LINE_IDX_WIDTH-1:0]   rd_req_tag,
    input  logic                                        rd_req_almostfull,
    input  logic                                        rd_rsp_valid,
    input  logic [$clog2(NUM_TBB)+LINE_IDX_WIDTH-1:0]   rd_rsp_tag,
    input  logic [LINE_DATA_WIDTH-1:0]                  rd_rsp_data
);

    localparam int ID_W    = $clog2(NUM_TBB);
    localparam int TAG_W   = ID_W + LINE_IDX_WIDTH;
    localparam int BATCH_W = ADDR_WIDTH - LINE_IDX_WIDTH;
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [LINE_IDX_WIDTH-1:0] LAST_LINE = '1;
    localparam logic [NUM_TBB-1:0]        ONE_HOT0  = {{(NUM_TBB-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                      state_q;
    logic [ADDR_WIDTH-1:0]       base_q;
    logic [BATCH_W-1:0]          num_q;
    logic [BATCH_W-1:0]          next_batch_q;
    logic [BATCH_W-1:0]          cur_batch_q [NUM_TBB];
    logic [NUM_TBB-1:0]          active_q;
    logic [OUT_W-1:0]            out_q;
    logic [ID_W-1:0]             rr_q;
    logic                        rd_req_valid_q;
    logic [ADDR_WIDTH-1:0]       rd_req_addr_q;
    logic [TAG_W-1:0]            rd_req_tag_q;
    logic [NUM_TBB-1:0]          wr_en_q;
    logic [LINE_IDX_WIDTH-1:0]   wr_addr_q;
    logic [LINE_DATA_WIDTH-1:0]  wr_din_q;

    logic [NUM_TBB-1:0]          elig;
    logic                        found;
    logic                        grant_en;
    logic                        rsp_take;
    logic [ID_W-1:0]             cand;
    logic [ID_W-1:0]             gnt_id;
    logic [LINE_IDX_WIDTH-1:0]   gnt_line;
    logic [BATCH_W-1:0]          gnt_batch;
    logic [OUT_W-1:0]            out_d;

    // Round-robin search begins at rr_q, which always points one past the last grant.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_TBB; i++) begin
            elig[i] = tbb_req_valid[i] &&
                      ((tbb_req_line_idx[i*LINE_IDX_WIDTH +: LINE_IDX_WIDTH] != '0) ||
                       (next_batch_q < num_q));
        end
        found  = 1'b0;
        gnt_id = '0;
        cand   = '0;
        for (int k = 0; k < NUM_TBB; k++) begin
            cand = rr_q + ID_W'(k);
            if (!found && elig[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end
        grant_en  = (state_q == S_RUN) && !rd_req_almostfull &&
                    (out_q < OUT_W'(MAX_OUTSTANDING)) && found;
        gnt_line  = tbb_req_line_idx[gnt_id*LINE_IDX_WIDTH +: LINE_IDX_WIDTH];
        gnt_batch = (gnt_line == '0) ? next_batch_q : cur_batch_q[gnt_id];
        rsp_take  = rd_rsp_valid && (state_q != S_IDLE);
        out_d     = out_q;
        if (grant_en && !rsp_take) begin
            out_d = out_q + 1'b1;
        end else if (!grant_en && rsp_take && (out_q != '0)) begin
            out_d = out_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            base_q         <= '0;
            num_q          <= '0;
            next_batch_q   <= '0;
            active_q       <= '0;
            out_q          <= '0;
            rr_q           <= '0;
            rd_req_valid_q <= 1'b0;
            rd_req_addr_q  <= '0;
            rd_req_tag_q   <= '0;
            wr_en_q        <= '0;
            wr_addr_q      <= '0;
            wr_din_q       <= '0;
            for (int i = 0; i < NUM_TBB; i++) begin
                cur_batch_q[i] <= '0;
            end
        end else begin
            rd_req_valid_q <= grant_en;
            out_q          <= out_d;
            wr_en_q        <= rsp_take ? (ONE_HOT0 << rd_rsp_tag[TAG_W-1 -: ID_W]) : '0;
            if (rsp_take) begin
                wr_addr_q <= rd_rsp_tag[LINE_IDX_WIDTH-1:0];
                wr_din_q  <= rd_rsp_data;
            end
            if (grant_en) begin
                rd_req_addr_q <= base_q + {gnt_batch, {LINE_IDX_WIDTH{1'b0}}} +
                                 ADDR_WIDTH'(gnt_line);
                rd_req_tag_q  <= {gnt_id, gnt_line};
                rr_q          <= gnt_id + 1'b1;
                if (gnt_line == '0) begin
                    cur_batch_q[gnt_id] <= next_batch_q;
                    next_batch_q        <= next_batch_q + 1'b1;
                    active_q[gnt_id]    <= 1'b1;
                end
                if (gnt_line == LAST_LINE) begin
                    active_q[gnt_id] <= 1'b0;
                end
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_RUN;
                        base_q       <= base_addr;
                        num_q        <= num_batches;
                        next_batch_q <= '0;
                        active_q     <= '0;
                    end
                end
                S_RUN: begin
                    if ((next_batch_q == num_q) && (active_q == '0)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_q == '0) begin
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs are forced low whenever reset_n is low, even before the first clock edge.
    assign done         = reset_n && (state_q == S_DONE);
    assign tbb_req_ack  = (reset_n && grant_en) ? (ONE_HOT0 << gnt_id) : '0;
    assign tbb_wr_en    = reset_n ? wr_en_q : '0;
    assign tbb_wr_addr  = reset_n ? wr_addr_q : '0;
    assign tbb_wr_din   = reset_n ? wr_din_q : '0;
    assign rd_req_valid = reset_n && rd_req_valid_q;
    assign rd_req_addr  = reset_n ? rd_req_addr_q : '0;
    assign rd_req_tag   = reset_n ? rd_req_tag_q : '0;

endmodule

// File: tb/tb_tbb_loader.sv
// tb/tb_tbb_loader.sv - scoreboard bench for tbb_loader with randomized TBB and host agents
module tb_tbb_loader;

    localparam int N    = 4;
    localparam int L    = 6;
    localparam int NL   = 64;
    localparam int MAXO = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  base_addr = '0;
    logic [25:0]  num_batches = '0;
    logic         done;
    logic [3:0]   tbb_req_valid = '0;
    logic [23:0]  tbb_req_line_idx = '0;
    logic [3:0]   tbb_req_ack;
    logic [3:0]   tbb_wr_en;
    logic [5:0]   tbb_wr_addr;
    logic [511:0] tbb_wr_din;
    logic         rd_req_valid;
    logic [31:0]  rd_req_addr;
    logic [7:0]   rd_req_tag;
    logic         rd_req_almostfull = 1'b0;
    logic         rd_rsp_valid = 1'b0;
    logic [7:0]   rd_rsp_tag = '0;
    logic [511:0] rd_rsp_data = '0;

    always #5 clk = ~clk;

    tbb_loader #(.NUM_TBB(4), .LINE_IDX_WIDTH(6), .LINE_DATA_WIDTH(512),
                 .ADDR_WIDTH(32), .MAX_OUTSTANDING(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .num_batches(num_batches), .done(done), .tbb_req_valid(tbb_req_valid),
        .tbb_req_line_idx(tbb_req_line_idx), .tbb_req_ack(tbb_req_ack),
        .tbb_wr_en(tbb_wr_en), .tbb_wr_addr(tbb_wr_addr), .tbb_wr_din(tbb_wr_din),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_tag(rd_req_tag),
        .rd_req_almostfull(rd_req_almostfull), .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_tag(rd_rsp_tag), .rd_rsp_data(rd_rsp_data)
    );

    typedef struct packed {logic [31:0] addr; logic [7:0] tag;} req_t;
    typedef struct packed {logic [3:0] en; logic [5:0] line; logic [511:0] data;} wr_t;

    req_t       exp_req[$];
    wr_t        exp_wr[$];
    logic [7:0] pool[$];
    logic [7:0] stale[$];
    int n_checks = 0;
    int n_err    = 0;
    int n_rd     = 0;
    int n_wr     = 0;

    bit          m_started = 0;
    logic [31:0] m_base = '0;
    int          m_num = 0, m_next = 0, m_out = 0, m_rr = 0;
    int          m_batch[N];
    bit          mid[N];
    int          lines[N];

    logic [3:0]  mask = '0;
    int          val_pct = 100, rsp_pct = 100, af_pct = 0;
    bit          lifo = 0, rnd_pick = 0, hold_full = 0;
    bit          af_now = 0, rsp_now = 0, start_now = 0;
    logic [31:0] st_base = '0;
    int          st_num = 0;

    task automatic chk(input bit ok, input string name, input logic [527:0] act,
                       input logic [527:0] exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit all_granted();
        bit r;
        r = (m_next >= m_num);
        for (int i = 0; i < N; i++) if (mid[i]) r = 0;
        return r;
    endfunction

    function automatic bit finished();
        return all_granted() && (m_out == 0);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a request or a write.
    always @(negedge clk) begin
        if (rd_req_valid === 1'b1) begin
            req_t e;
            n_rd++;
            if (exp_req.size() == 0) begin
                chk(0, "unexpected_rd_req", {rd_req_addr, rd_req_tag}, '0);
            end else begin
                e = exp_req.pop_front();
                chk({rd_req_addr, rd_req_tag} === e, "rd_req", {rd_req_addr, rd_req_tag}, e);
            end
            pool.push_back(rd_req_tag);
        end
        if (tbb_wr_en !== 4'b0) begin
            wr_t w;
            n_wr++;
            if (exp_wr.size() == 0) begin
                chk(0, "unexpected_wr", {tbb_wr_en, tbb_wr_addr, tbb_wr_din}, '0);
            end else begin
                w = exp_wr.pop_front();
                chk({tbb_wr_en, tbb_wr_addr, tbb_wr_din} === w, "tbb_wr",
                    {tbb_wr_en, tbb_wr_addr, tbb_wr_din}, w);
            end
        end
    end

    // Reference model: decides the grant for the cycle now ending and updates the bookkeeping.
    task automatic eval_cycle();
        int g, c, line;
        logic [3:0] elig, eack;
        logic [31:0] addr;
        if (!finished()) chk(done === 1'b0, "done_early", done, 0);
        g = -1;
        for (int i = 0; i < N; i++)
            elig[i] = tbb_req_valid[i] && (lines[i] != 0 || m_next < m_num);
        if (m_started && !af_now && m_out < MAXO)
            for (int k = 0; k < N; k++) begin
                c = (m_rr + k) % N;
                if (g < 0 && elig[c]) g = c;
            end
        eack = (g >= 0) ? 4'(1 << g) : 4'b0;
        chk(tbb_req_ack === eack, "ack", tbb_req_ack, eack);
        if (g >= 0) begin
            line = lines[g];
            if (line == 0) begin
                m_batch[g] = m_next;
                m_next++;
                mid[g] = 1;
            end
            if (line == NL - 1) mid[g] = 0;
            addr = m_base + 32'(m_batch[g] * NL) + 32'(line);
            exp_req.push_back({addr, 2'(g), 6'(line)});
            m_rr = (g + 1) % N;
            lines[g] = (line + 1) % NL;
            m_out++;
        end
        if (rsp_now && m_started) m_out--;
        if (start_now && (!m_started || finished())) begin
            m_started = 1;
            m_base = st_base;
            m_num = st_num;
            m_next = 0;
            for (int i = 0; i < N; i++) mid[i] = 0;
        end
    endtask

    task automatic cycle();
        int idx;
        logic [7:0] tg;
        logic [511:0] dat;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            tbb_req_valid[i] = mask[i] && ($urandom_range(0, 99) < val_pct);
            tbb_req_line_idx[i*L +: L] = 6'(lines[i]);
        end
        rd_req_almostfull = af_now;
        rsp_now = 0;
        rd_rsp_valid = 0;
        if (pool.size() > 0 && !(hold_full && pool.size() < MAXO && !all_granted()) &&
            $urandom_range(0, 99) < rsp_pct) begin
            idx = lifo ? pool.size() - 1 : (rnd_pick ? int'($urandom_range(0, pool.size() - 1)) : 0);
            tg = pool[idx];
            pool.delete(idx);
            for (int k = 0; k < 16; k++) dat[k*32 +: 32] = $urandom;
            rd_rsp_valid = 1;
            rd_rsp_tag = tg;
            rd_rsp_data = dat;
            rsp_now = 1;
            if (m_started) exp_wr.push_back({4'(1 << tg[7:6]), tg[5:0], dat});
        end
        start = start_now;
        base_addr = st_base;
        num_batches = 26'(st_num);
        @(negedge clk);
        eval_cycle();
        start_now = 0;
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #1;
        reset_n = 0;
        start = 0;
        rd_rsp_valid = 0;
        rd_req_almostfull = 0;
        tbb_req_valid = 4'hF;
        @(negedge clk);
        chk(done === 1'b0, "rst_done", done, 0);
        chk(tbb_req_ack === 4'b0, "rst_ack", tbb_req_ack, 0);
        chk(tbb_wr_en === 4'b0, "rst_wr_en", tbb_wr_en, 0);
        chk(tbb_wr_addr === 6'b0, "rst_wr_addr", tbb_wr_addr, 0);
        chk(tbb_wr_din === 512'b0, "rst_wr_din", tbb_wr_din, 0);
        chk(rd_req_valid === 1'b0, "rst_rd_valid", rd_req_valid, 0);
        chk(rd_req_addr === 32'b0, "rst_rd_addr", rd_req_addr, 0);
        chk(rd_req_tag === 8'b0, "rst_rd_tag", rd_req_tag, 0);
        repeat (hold) @(posedge clk);
        #1;
        reset_n = 1;
        tbb_req_valid = 0;
        stale = pool;
        pool.delete();
        exp_req.delete();
        exp_wr.delete();
        m_started = 0; m_base = 0; m_num = 0; m_next = 0; m_out = 0; m_rr = 0;
        for (int i = 0; i < N; i++) begin
            lines[i] = 0; mid[i] = 0; m_batch[i] = 0;
        end
    endtask

    task automatic run_phase(input logic [3:0] msk, input logic [31:0] base, input int num,
                             input int vpct, input int rpct, input bit lf, input bit rp,
                             input bit hf, input int afp, input int af_at, input int ign_at,
                             input int limit, input bit expect_done);
        bit ok;
        mask = msk; val_pct = vpct; rsp_pct = rpct; lifo = lf; rnd_pick = rp;
        hold_full = hf; af_pct = afp; af_now = 0;
        st_base = base; st_num = num; start_now = 1;
        n_rd = 0; n_wr = 0;
        cycle();
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            af_now = (i >= af_at && i < af_at + 10) || ($urandom_range(0, 99) < af_pct);
            if (i == ign_at) begin
                st_base = base + 32'h0004_0000;
                st_num = num + 3;
                start_now = 1;
            end
            cycle();
            if (i == 0) chk(done === 1'b0, "done_clear_after_start", done, 0);
            if (expect_done && finished() && pool.size() == 0 &&
                exp_req.size() == 0 && exp_wr.size() == 0) begin
                ok = 1;
                break;
            end
        end
        af_now = 0;
        if (expect_done) begin
            chk(ok, "phase_complete", 528'(ok), 1);
            ok = 0;
            for (int i = 0; i < 8 && !ok; i++) begin
                cycle();
                ok = (done === 1'b1);
            end
            chk(ok, "done_set", done, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            lines[i] = 0; mid[i] = 0; m_batch[i] = 0;
        end
        do_reset(3);
        // Single TBB, one batch at 0x1000, in-order responses
        run_phase(4'b0001, 32'h1000, 1, 100, 100, 0, 0, 0, 0, -100, -1, 2000, 1);
        chk(n_rd == 64, "single_tbb_requests", 528'(n_rd), 64);
        chk(n_wr == 64, "single_tbb_writes", 528'(n_wr), 64);
        // Four TBBs, almostfull window, ignored start while running
        run_phase(4'b1111, 32'h0002_0000, 4, 100, 60, 0, 1, 0, 0, 40, 30, 4000, 1);
        chk(n_wr == 256, "four_tbb_writes", 528'(n_wr), 256);
        // Credit saturation with reversed responses, address wrap past 2^32
        run_phase(4'b0011, 32'hFFFF_FF80, 3, 100, 100, 1, 0, 1, 0, -100, -1, 4000, 1);
        // Two batches, three requesters
        run_phase(4'b0111, 32'h0000_4000, 2, 100, 80, 0, 0, 0, 0, -100, -1, 3000, 1);
        chk(n_wr == 128, "two_batch_writes", 528'(n_wr), 128);
        // Zero batches
        run_phase(4'b1111, 32'h0000_8000, 0, 100, 100, 0, 0, 0, 0, -100, -1, 50, 1);
        chk(n_rd == 0, "zero_batch_requests", 528'(n_rd), 0);
        // Reset mid-run, then stale responses while idle must not write
        run_phase(4'b1111, 32'h0001_0000, 3, 100, 30, 0, 1, 0, 0, -100, -1, 60, 0);
        do_reset(2);
        mask = 0; rsp_pct = 100; lifo = 0; rnd_pick = 0; hold_full = 0;
        pool = stale;
        for (int i = 0; i < 40 && pool.size() > 0; i++) cycle();
        repeat (3) cycle();
        for (int r = 0; r < 4; r++) begin
            run_phase(4'($urandom_range(1, 15)), $urandom, int'($urandom_range(0, 5)),
                      int'($urandom_range(50, 100)), int'($urandom_range(20, 90)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 10,
                      -100, -1, 8000, 1);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
